// File: rtl/score_sseg_driver_pkg.sv
// Shared constants, segment table and converter state type for the score display.
// Segment codes are active-low gfedcba; the dp bit is added by the driver.
package sseg_pkg;
  localparam int SSEG_DIGITS = 4;
  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam int BCD_MAX = 9999;
  localparam logic [15:0] BCD_MAX_BCD = 16'h9999;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SSEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
    if (blank || digit > 4'd9) return SSEG_BLANK;
    return SSEG_LUT[digit];
  endfunction
endpackage

// File: rtl/score_sseg_driver_if.sv
// Score in, multiplexed seven-segment drive and busy out; blink exists only with SSEG_BLINK_EN.
// No backpressure: score is sampled whenever the converter is idle.
interface score_sseg_driver_if #(parameter int SCORE_W = 8);
  logic [SCORE_W-1:0] score;
  logic [7:0]         sseg_a_to_dp;
  logic [3:0]         sseg_an;
  logic               busy;
`ifdef SSEG_BLINK_EN
  logic               blink;
  modport master (output score, blink, input sseg_a_to_dp, sseg_an, busy);
  modport slave  (input score, blink, output sseg_a_to_dp, sseg_an, busy);
`else
  modport master (output score, input sseg_a_to_dp, sseg_an, busy);
  modport slave  (input score, output sseg_a_to_dp, sseg_an, busy);
`endif
endinterface

// File: rtl/score_sseg_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD, saturating at 9999.
// Latency: start to done = SCORE_W+1 cycles; start is ignored unless idle.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] value,
  output logic               idle,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bcd
);
  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_t        state, state_nxt;
  logic [SCORE_W-1:0] sh, sh_nxt;
  logic [19:0]        acc, acc_nxt, adj;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // Five nibbles so 16-bit inputs (up to 65535) convert before saturation.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          sh_nxt    = value;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = {adj[18:0], sh[SCORE_W-1]};
        sh_nxt  = sh << 1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign idle = (state == IDLE);
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign bcd  = (acc[19:16] != 4'd0) ? BCD_MAX_BCD : acc[15:0];
endmodule

// File: rtl/score_sseg_driver.sv
// Decimal score on a 4-digit multiplexed display with leading-zero blanking; SSEG_BLINK_EN adds blink.
// Latency: score change to new digits SCORE_W+2 cycles, segments one cycle later; no backpressure.
module score_sseg_driver
  import sseg_pkg::*;
#(
  parameter int SCORE_W  = 8,
  parameter int SCAN_DIV = 12500
) (
  input  logic                sys_clk,
  input  logic                reset_p,
  score_sseg_driver_if.slave  bus
);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [SCORE_W-1:0] last, inflight;
  logic               start, conv_idle, conv_busy, conv_done;
  logic [15:0]        conv_bcd, digits;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic               scan_wrap;
  logic [SSEG_DIGITS-1:0] blank;
  logic [3:0]         an_nxt, an_q;
  logic [7:0]         seg_q;

  assign start = conv_idle && (bus.score != last);

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
    .clk   (sys_clk),
    .rst   (reset_p),
    .start (start),
    .value (bus.score),
    .idle  (conv_idle),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // last tracks what is on display, so a change during conversion is caught afterwards.
  always_ff @(posedge sys_clk or posedge reset_p) begin
    if (reset_p) begin
      inflight <= '0;
      last     <= '0;
      digits   <= '0;
    end else begin
      if (start) inflight <= bus.score;
      if (conv_done) begin
        digits <= conv_bcd;
        last   <= inflight;
      end
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge sys_clk or posedge reset_p) begin
    if (reset_p) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) idx <= idx + 1'b1;
    end
  end

  assign blank[3] = (digits[15:12] == 4'd0);
  assign blank[2] = blank[3] && (digits[11:8] == 4'd0);
  assign blank[1] = blank[2] && (digits[7:4] == 4'd0);
  assign blank[0] = 1'b0;

`ifdef SSEG_BLINK_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge sys_clk or posedge reset_p) begin
    if (reset_p)                      frame_cnt <= '0;
    else if (scan_wrap && idx == 2'd3) frame_cnt <= frame_cnt + 1'b1;
  end

  assign an_nxt = (bus.blink && frame_cnt[7]) ? 4'b1111 : ~(4'b0001 << idx);
`else
  assign an_nxt = ~(4'b0001 << idx);
`endif

  always_ff @(posedge sys_clk or posedge reset_p) begin
    if (reset_p) begin
      an_q  <= 4'b1111;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= an_nxt;
      seg_q <= {1'b1, seg_encode(digits[4*idx +: 4], blank[idx])};
    end
  end

  assign bus.sseg_an      = an_q;
  assign bus.sseg_a_to_dp = seg_q;
  assign bus.busy         = conv_busy;
endmodule

// File: tb/tb_score_sseg_driver.sv
// Randomized score stimulus against a decimal reference model on an 8-bit and a 14-bit instance.
module tb_score_sseg_driver;
  localparam int W1 = 8;
  localparam int W2 = 14;
  localparam int SD = 4;

  logic sys_clk = 1'b0;
  logic reset_p = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  score_sseg_driver_if #(.SCORE_W(W1)) bus1 ();
  score_sseg_driver_if #(.SCORE_W(W2)) bus2 ();

  score_sseg_driver #(.SCORE_W(W1), .SCAN_DIV(SD)) dut1 (
    .sys_clk (sys_clk), .reset_p (reset_p), .bus (bus1));
  score_sseg_driver #(.SCORE_W(W2), .SCAN_DIV(SD)) dut2 (
    .sys_clk (sys_clk), .reset_p (reset_p), .bus (bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: saturate, take the decimal digit, blank if the value has fewer digits.
  function automatic logic [7:0] exp_seg(input int val, input int d);
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int v, p;
    v = (val > 9999) ? 9999 : val;
    p = 1;
    repeat (d) p = p * 10;
    if (d > 0 && v < p) return 8'hFF;
    return {1'b1, lut[(v / p) % 10]};
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? bus1.busy : bus2.busy;
  endfunction

  // Counts busy-high cycles until busy falls, bounded.
  task automatic measure(input int which, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (busy_of(which)) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic check_frame(input int which, input int val, input string tag);
    logic [3:0][8:0] seen;
    logic [3:0] an;
    logic [7:0] seg;
    for (int d = 0; d < 4; d++) seen[d] = 9'h100;
    for (int i = 0; i < 6 * SD; i++) begin
      @(negedge sys_clk);
      an  = (which == 0) ? bus1.sseg_an : bus2.sseg_an;
      seg = (which == 0) ? bus1.sseg_a_to_dp : bus2.sseg_a_to_dp;
      for (int d = 0; d < 4; d++)
        if (an == ~(4'b0001 << d)) seen[d] = {1'b0, seg};
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_v%0d_d%0d", tag, val, d), 32'(seen[d]), {23'd0, 1'b0, exp_seg(val, d)});
  endtask

  task automatic convert(input int which, input int val, input string tag);
    int n;
    if (which == 0) bus1.score = W1'(val);
    else            bus2.score = W2'(val);
    measure(which, n);
    chk({tag, "_busy_len"}, n, (which == 0) ? W1 : W2);
    repeat (2) @(negedge sys_clk);
    check_frame(which, val, tag);
  endtask

  initial begin
    int cur1, cur2, v, n, rises, hi;
    logic prev;
    bus1.score = '0;
    bus2.score = '0;
`ifdef SSEG_BLINK_EN
    bus1.blink = 1'b0;
    bus2.blink = 1'b0;
`endif
    repeat (3) @(negedge sys_clk);
    chk("rst_an", 32'(bus1.sseg_an), 32'hF);
    chk("rst_seg", 32'(bus1.sseg_a_to_dp), 32'hFF);
    chk("rst_busy", 32'(bus1.busy), 32'h0);
    reset_p = 1'b0;
    check_frame(0, 0, "zero");
    chk("zero_no_busy", 32'(bus1.busy), 32'h0);

    convert(0, 123, "fixed");
    convert(0, 105, "fixed");
    cur1 = 105;
    for (int k = 0; k < 8; k++) begin
      v = $urandom_range(0, 255);
      if (v == cur1) v = (v + 1) % 256;
      convert(0, v, "rand8");
      cur1 = v;
    end
    if (cur1 == 200) convert(0, 7, "pre");

    // Score changes on the second cycle of an in-flight conversion.
    bus1.score = 8'd200;
    rises = 0; hi = 0; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (bus1.busy && !prev) rises++;
      if (bus1.busy) hi++;
      if (hi == 1) bus1.score = 8'd201;
      prev = bus1.busy;
    end
    chk("midchg_rises", rises, 2);
    chk("midchg_busy_cycles", hi, 2 * W1);
    check_frame(0, 201, "midchg");

    convert(1, 12000, "sat");
    cur2 = 12000;
    for (int k = 0; k < 5; k++) begin
      v = (k % 2 == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      if (v == cur2) v = v ^ 1;
      convert(1, v, "rand14");
      cur2 = v;
    end

    // Reset asserted while busy, then reconversion of the held score.
    bus1.score = 8'd57;
    @(negedge sys_clk);
    chk("rstmid_busy_before", 32'(bus1.busy), 32'h1);
    @(negedge sys_clk);
    reset_p = 1'b1;
    #1;
    chk("rstmid_an", 32'(bus1.sseg_an), 32'hF);
    chk("rstmid_seg", 32'(bus1.sseg_a_to_dp), 32'hFF);
    chk("rstmid_busy", 32'(bus1.busy), 32'h0);
    @(negedge sys_clk);
    reset_p = 1'b0;
    measure(0, n);
    chk("rstmid_busy_len", n, W1);
    repeat (2) @(negedge sys_clk);
    check_frame(0, 57, "rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
